// File: rtl/image_pkg.sv
// Shared definitions for the image pipeline: receiver FSM states and the
// default frame/UART constants used by the loader, image_read and image_write.
package image_pkg;

  // 50 MHz / 115200 baud
  localparam int unsigned CLKS_PER_BIT_115200 = 434;
  // 768 x 512 pixels x 3 bytes (RGB)
  localparam int unsigned FRAME_BYTES_768x512 = 1179648;
  // Smallest width whose range covers a full frame
  localparam int unsigned IMG_ADDR_WIDTH      = 21;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver (LSB first): 2-FF synchronizer, bit FSM and shift register.
// Ports:
//   HCLK, HRESET : clock, synchronous active-high reset
//   RxD          : asynchronous serial input, idle high
//   rx_valid_c   : one-cycle pulse during the stop-bit sample cycle (good stop)
//   rx_ferr_c    : one-cycle pulse during the stop-bit sample cycle (low stop)
//   rx_byte      : shift register contents, valid alongside rx_valid_c
//   rx_busy      : high whenever the FSM is outside IDLE
module uart_rx_core
  import image_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       RxD,
  output logic       rx_valid_c,
  output logic [7:0] rx_byte,
  output logic       rx_ferr_c,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       r_sync;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_busy;

  logic             w_rxs;
  rx_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       w_shift_nxt;

  assign w_rxs   = r_sync[1];
  assign rx_byte = r_shift;
  assign rx_busy = r_busy;

  // State and datapath registers; synchronizer resets to the idle level
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync  <= 2'b11;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], RxD};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state logic; every sample is taken at a bit midpoint
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    rx_valid_c  = 1'b0;
    rx_ferr_c   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = '0;
        end
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          // A start bit that is gone by mid-bit is a glitch
          w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt            = '0;
          w_shift_nxt[r_idx]   = w_rxs;
          if (r_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            rx_valid_c  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            rx_ferr_c   = 1'b1;
            w_state_nxt = ST_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off until a break ends so it is not taken as a start bit
        if (w_rxs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_image_loader.sv
// Receives a raw RGB frame over UART and writes each byte to image memory at a
// sequential address, flagging frame completion and framing errors.
// Ports:
//   HCLK, HRESET   : clock, synchronous active-high reset
//   RxD            : asynchronous serial input, idle high
//   mem_we         : one-cycle write strobe
//   mem_addr       : write address (byte index in frame), qualify with mem_we
//   mem_wdata      : written byte, qualify with mem_we
//   byte_count     : bytes written this frame (saturates at FRAME_BYTES)
//   rx_busy        : receiver is mid-character
//   frame_done     : sticky, full frame written
//   framing_error  : sticky, a stop bit was sampled low
module uart_image_loader
  import image_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int unsigned FRAME_BYTES  = FRAME_BYTES_768x512,
  parameter int unsigned ADDR_WIDTH   = IMG_ADDR_WIDTH
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  RxD,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [ADDR_WIDTH-1:0] byte_count,
  output logic                  rx_busy,
  output logic                  frame_done,
  output logic                  framing_error
);

  localparam logic [ADDR_WIDTH-1:0] FRAME_LAST = ADDR_WIDTH'(FRAME_BYTES);

  logic                  w_rx_valid;
  logic                  w_rx_ferr;
  logic [7:0]            w_rx_byte;
  logic                  w_full;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_done;
  logic                  r_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .RxD        (RxD),
    .rx_valid_c (w_rx_valid),
    .rx_byte    (w_rx_byte),
    .rx_ferr_c  (w_rx_ferr),
    .rx_busy    (rx_busy)
  );

  // Full-width compare so the counter can never wrap past the frame
  assign w_full = (r_count == FRAME_LAST);

  // Write port, byte counter and sticky status flags
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= r_done | w_full;
      r_ferr <= r_ferr | w_rx_ferr;
      if (w_rx_valid && !w_full) begin
        r_we    <= 1'b1;
        r_addr  <= r_count;
        r_wdata <= w_rx_byte;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign byte_count    = r_count;
  assign frame_done    = r_done;
  assign framing_error = r_ferr;

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader: a fast instance (4-cycle bits, 4-byte frame)
// for directed and random cases, and a 434-cycle-bit instance for a random run.
module tb_uart_image_loader;

  localparam int unsigned F_CPB = 4;
  localparam int unsigned F_FB  = 4;
  localparam int unsigned F_AW  = 3;
  localparam int unsigned S_CPB = 434;
  localparam int unsigned S_FB  = 32;
  localparam int unsigned S_AW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rxd_f, rxd_s;

  logic            f_we, f_busy, f_done, f_ferr;
  logic [F_AW-1:0] f_addr, f_cnt;
  logic [7:0]      f_wdata;
  logic            s_we, s_busy, s_done, s_ferr;
  logic [S_AW-1:0] s_addr, s_cnt;
  logic [7:0]      s_wdata;

  uart_image_loader #(.CLKS_PER_BIT(F_CPB), .FRAME_BYTES(F_FB), .ADDR_WIDTH(F_AW)) dut (
    .HCLK(clk), .HRESET(rst), .RxD(rxd_f),
    .mem_we(f_we), .mem_addr(f_addr), .mem_wdata(f_wdata), .byte_count(f_cnt),
    .rx_busy(f_busy), .frame_done(f_done), .framing_error(f_ferr)
  );

  uart_image_loader #(.CLKS_PER_BIT(S_CPB), .FRAME_BYTES(S_FB), .ADDR_WIDTH(S_AW)) dut_slow (
    .HCLK(clk), .HRESET(rst), .RxD(rxd_s),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata), .byte_count(s_cnt),
    .rx_busy(s_busy), .frame_done(s_done), .framing_error(s_ferr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed writes, packed as (addr << 8) | data
  int wq_f[$];
  int wq_s[$];
  int cyc = 0;
  int last_wr_cyc = -100;
  int done_cyc = -200;
  bit prev_done = 1'b0;
  bit busy_seen_f = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (f_we) begin
      wq_f.push_back((int'(f_addr) << 8) | int'(f_wdata));
      if (int'(f_addr) == F_FB - 1) last_wr_cyc = cyc;
    end
    if (f_done && !prev_done) done_cyc = cyc;
    prev_done = f_done;
    if (f_busy) busy_seen_f = 1'b1;
    if (s_we) wq_s.push_back((int'(s_addr) << 8) | int'(s_wdata));
  end

  // Reference model of the fast instance: what memory should see
  int eq_f[$];
  int eq_s[$];
  int m_cnt;
  bit m_done, m_ferr;

  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!good) m_ferr = 1'b1;
    else if (m_cnt < F_FB) begin
      eq_f.push_back((m_cnt << 8) | int'(b));
      m_cnt++;
    end
    m_done = (m_cnt == F_FB);
  endfunction

  task automatic line_bits(input bit slow, input logic v, input int nbits);
    int cpb;
    cpb = slow ? S_CPB : F_CPB;
    for (int i = 0; i < nbits * cpb; i++) begin
      @(negedge clk);
      if (slow) rxd_s = v;
      else      rxd_f = v;
    end
  endtask

  // One 8N1 character; low_stop > 0 holds the stop bit low that many bit-times
  task automatic send(input bit slow, input logic [7:0] b, input int low_stop);
    line_bits(slow, 1'b0, 1);
    for (int i = 0; i < 8; i++) line_bits(slow, b[i], 1);
    if (low_stop > 0) line_bits(slow, 1'b0, low_stop);
    line_bits(slow, 1'b1, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    rxd_f = 1'b1;
    rxd_s = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wq_f.delete(); eq_f.delete();
    m_cnt = 0; m_done = 1'b0; m_ferr = 1'b0;
    busy_seen_f = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(f_we),    32'd0);
    check({tag, "_addr"},  32'(f_addr),  32'd0);
    check({tag, "_wdata"}, 32'(f_wdata), 32'd0);
    check({tag, "_cnt"},   32'(f_cnt),   32'd0);
    check({tag, "_busy"},  32'(f_busy),  32'd0);
    check({tag, "_done"},  32'(f_done),  32'd0);
    check({tag, "_ferr"},  32'(f_ferr),  32'd0);
  endtask

  task automatic compare_f(input string tag);
    int n;
    check({tag, "_nwr"}, 32'(wq_f.size()), 32'(eq_f.size()));
    n = (wq_f.size() < eq_f.size()) ? wq_f.size() : eq_f.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(wq_f[i]), 32'(eq_f[i]));
    check({tag, "_cnt"},  32'(f_cnt),  32'(m_cnt));
    check({tag, "_done"}, 32'(f_done), 32'(m_done));
    check({tag, "_ferr"}, 32'(f_ferr), 32'(m_ferr));
    check({tag, "_busy"}, 32'(f_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    bit bad;
    int nlow;
    rst = 1'b1; rxd_f = 1'b1; rxd_s = 1'b1;
    do_reset();
    check_zero("rst");

    // Single byte after reset
    send(1'b0, 8'hA5, 0); model_byte(8'hA5, 1'b1);
    line_bits(1'b0, 1'b1, 3);
    compare_f("single");

    // Back-to-back fill of the frame, then one byte past the end
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      send(1'b0, b, 0); model_byte(b, 1'b1);
    end
    send(1'b0, 8'hFF, 0); model_byte(8'hFF, 1'b1);
    line_bits(1'b0, 1'b1, 3);
    compare_f("frame");
    check("frame_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);

    // One-cycle low glitch on the line
    do_reset();
    @(negedge clk); rxd_f = 1'b0;
    @(negedge clk); rxd_f = 1'b1;
    line_bits(1'b0, 1'b1, 4);
    check("glitch_busy_seen", 32'(busy_seen_f), 32'd1);
    compare_f("glitch");

    // Stop bit held low (break), then a clean byte
    do_reset();
    send(1'b0, 8'h3C, 3); model_byte(8'h3C, 1'b0);
    send(1'b0, 8'h55, 0); model_byte(8'h55, 1'b1);
    line_bits(1'b0, 1'b1, 3);
    compare_f("ferr");

    // Reset in the middle of data bit 4 of 0x77
    do_reset();
    b = 8'h77;
    line_bits(1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) line_bits(1'b0, b[i], 1);
    @(negedge clk); rxd_f = b[4];
    @(negedge clk);
    check("midrst_busy", 32'(f_busy), 32'd1);
    do_reset();
    check_zero("midrst");
    send(1'b0, 8'h99, 0); model_byte(8'h99, 1'b1);
    line_bits(1'b0, 1'b1, 3);
    compare_f("midrst");

    // Random bytes with random bad stops and gaps, past the frame end
    do_reset();
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      nlow = bad ? int'($urandom_range(1, 3)) : 0;
      send(1'b0, b, nlow); model_byte(b, !bad);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    line_bits(1'b0, 1'b1, 3);
    compare_f("rand");

    // Real baud divisor, 16 random bytes
    wq_s.delete();
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      eq_s.push_back((k << 8) | int'(b));
      send(1'b1, b, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    line_bits(1'b1, 1'b1, 2);
    check("slow_nwr", 32'(wq_s.size()), 32'd16);
    for (int i = 0; i < 16 && i < wq_s.size(); i++)
      check($sformatf("slow_wr%0d", i), 32'(wq_s[i]), 32'(eq_s[i]));
    check("slow_cnt",  32'(s_cnt),  32'd16);
    check("slow_done", 32'(s_done), 32'd0);
    check("slow_ferr", 32'(s_ferr), 32'd0);
    check("slow_busy", 32'(s_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
